// File: rtl/fetch_prefetch_if.sv
// W-bus signal bundle between the fetch unit (master) and the memory slave.
// The master drives strobe/direction/address/write data; the slave answers with read data and ack.
interface fetch_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              W_STB;
    logic              W_WRITE;
    logic [ADDR_W-1:0] W_ADDR;
    logic [DATA_W-1:0] W_DATA_O;
    logic [DATA_W-1:0] W_DATA_I;
    logic              W_ACK;

    modport master (
        output W_STB,
        output W_WRITE,
        output W_ADDR,
        output W_DATA_O,
        input  W_DATA_I,
        input  W_ACK
    );

    modport slave (
        input  W_STB,
        input  W_WRITE,
        input  W_ADDR,
        input  W_DATA_O,
        output W_DATA_I,
        output W_ACK
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Sequential instruction prefetcher with a DEPTH-entry word buffer, redirect flush and
// single-store pass-through onto the W-bus; one clock, asynchronous active-high reset.
module fetch_prefetch #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_STEP = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_enable,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ack,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ack,
    output logic [1:0]        state_o,
    fetch_prefetch_if.master  w_bus
);
    // Core side: f_enable is a request sampled each edge, ack is a one-cycle
    // pulse carrying data_o/pc_o. st_req is held until st_ack pulses.
    // Bus side: W_STB and its qualifiers stay stable until the edge sampling W_ACK=1.

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RD_WAIT    = 2'd1,
        RD_DISCARD = 2'd2,
        WR_WAIT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] buf_data_q [DEPTH];
    logic [DATA_W-1:0] buf_data_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic [ADDR_W-1:0] pc_o_q, pc_o_d;
    logic              ack_q, ack_d;
    logic              st_ack_q, st_ack_d;
    logic              stb_q, stb_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic bus_ack;
    logic push;
    logic pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_o_q   <= '0;
            pc_o_q     <= '0;
            ack_q      <= 1'b0;
            st_ack_q   <= 1'b0;
            stb_q      <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_o_q   <= data_o_d;
            pc_o_q     <= pc_o_d;
            ack_q      <= ack_d;
            st_ack_q   <= st_ack_d;
            stb_q      <= stb_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        data_o_d   = data_o_q;
        pc_o_d     = pc_o_q;
        ack_d      = 1'b0;
        st_ack_d   = 1'b0;
        stb_d      = stb_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        push       = 1'b0;

        bus_ack = w_bus.W_ACK & stb_q;
        pop     = f_enable && (count_q != '0) && !redirect;

        case (state_q)
            IDLE: begin
                // st_ack_q blocks the edge where the core still holds the finished request.
                if (st_req && !st_ack_q) begin
                    state_d = WR_WAIT;
                    stb_d   = 1'b1;
                    write_d = 1'b1;
                    addr_d  = st_addr;
                    wdata_d = st_data;
                end else if ((count_q < DEPTH_C) && !redirect) begin
                    state_d = RD_WAIT;
                    stb_d   = 1'b1;
                    write_d = 1'b0;
                    addr_d  = fetch_pc_q;
                end
            end
            RD_WAIT: begin
                if (redirect) begin
                    if (bus_ack) begin
                        state_d = IDLE;
                        stb_d   = 1'b0;
                    end else begin
                        state_d = RD_DISCARD;
                    end
                end else if (bus_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + STEP_C;
                    state_d    = IDLE;
                    stb_d      = 1'b0;
                end
            end
            RD_DISCARD: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                end
            end
            WR_WAIT: begin
                if (bus_ack) begin
                    st_ack_d = 1'b1;
                    state_d  = IDLE;
                    stb_d    = 1'b0;
                    write_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase

        if (push) begin
            buf_data_d[wr_ptr_q] = w_bus.W_DATA_I;
            buf_pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            data_o_d = buf_data_q[rd_ptr_q];
            pc_o_d   = buf_pc_q[rd_ptr_q];
            ack_d    = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // A redirect wins over everything in the buffer, whatever state the bus is in.
        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_addr;
        end
    end

    assign data_o         = data_o_q;
    assign pc_o           = pc_o_q;
    assign ack            = ack_q;
    assign st_ack         = st_ack_q;
    assign state_o        = state_q;
    assign w_bus.W_STB    = stb_q;
    assign w_bus.W_WRITE  = write_q;
    assign w_bus.W_ADDR   = addr_q;
    assign w_bus.W_DATA_O = wdata_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: W-bus slave model, instruction-stream scoreboard, directed
// scenarios followed by randomized fetch/redirect/store traffic.
module tb_fetch_prefetch;
    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] STEP     = 32'd4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_enable;
    logic [DATA_W-1:0] data_o;
    logic [ADDR_W-1:0] pc_o;
    logic              ack;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ack;
    logic [1:0]        state_o;

    fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) w_bus ();

    fetch_prefetch #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ADDR_STEP(4), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .f_enable(f_enable), .data_o(data_o), .pc_o(pc_o), .ack(ack),
        .redirect(redirect), .redirect_addr(redirect_addr), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_ack(st_ack), .state_o(state_o), .w_bus(w_bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // ---------------- bus slave model ----------------
    int          wait_mode = 0;
    int          cur_wait  = 0;
    int          wcnt      = 0;
    logic        prev_stb  = 1'b0;
    logic [33:0] prev_hold = '0;
    logic [31:0] prev_wdata = '0;
    logic [31:0] rd_log[$];
    logic [32:0] txn_log[$];
    logic [63:0] wr_log[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            w_bus.W_ACK = 1'b0;
            wcnt        = 0;
            prev_stb    = 1'b0;
        end else begin
            if (w_bus.W_ACK) begin
                check("stb_gap", 64'(w_bus.W_STB), 64'd0);
                w_bus.W_ACK = 1'b0;
            end else begin
                if (prev_stb) begin
                    check("bus_hold", 64'({w_bus.W_STB, w_bus.W_WRITE, w_bus.W_ADDR}), 64'(prev_hold));
                    if (w_bus.W_WRITE) check("bus_hold_wdata", 64'(w_bus.W_DATA_O), 64'(prev_wdata));
                end
                if (w_bus.W_STB) begin
                    if (!prev_stb) begin
                        wcnt     = 0;
                        cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                        txn_log.push_back({w_bus.W_WRITE, w_bus.W_ADDR});
                        if (!w_bus.W_WRITE) rd_log.push_back(w_bus.W_ADDR);
                    end
                    if (wcnt >= cur_wait) begin
                        w_bus.W_ACK = 1'b1;
                        if (w_bus.W_WRITE) wr_log.push_back({w_bus.W_ADDR, w_bus.W_DATA_O});
                        else w_bus.W_DATA_I = mem_word(w_bus.W_ADDR);
                    end else begin
                        wcnt++;
                    end
                end
            end
            prev_stb   = w_bus.W_STB;
            prev_hold  = {w_bus.W_STB, w_bus.W_WRITE, w_bus.W_ADDR};
            prev_wdata = w_bus.W_DATA_O;
        end
    end

    // ---------------- scoreboard: the core must see an unbroken address run ----------------
    logic [31:0] exp_q[$];
    int          ack_cnt     = 0;
    int          st_ack_cnt  = 0;
    logic [31:0] last_ack_pc = '0;
    logic        ack_blocked = 1'b0;
    logic        first_after = 1'b0;
    logic        prev_st_ack = 1'b0;
    int          since       = 1000;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            ack_blocked = 1'b0;
            first_after = 1'b0;
            prev_st_ack = 1'b0;
            since       = 1000;
        end else begin
            since++;
            if (ack_blocked) begin
                check("ack_on_redirect_edge", 64'(ack), 64'd0);
            end else if (ack) begin
                ack_cnt++;
                last_ack_pc = pc_o;
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_pc", 64'(pc_o), 64'(e));
                    check("ack_data", 64'(data_o), 64'(mem_word(e)));
                end
                if (first_after) begin
                    check("redirect_latency", 64'(since >= 4), 64'd1);
                    first_after = 1'b0;
                end
            end
            if (st_ack) begin
                st_ack_cnt++;
                check("st_ack_pulse", 64'(prev_st_ack), 64'd0);
            end
            prev_st_ack = st_ack;
            ack_blocked = 1'b0;
            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_addr);
                ack_blocked = 1'b1;
                first_after = 1'b1;
                since       = 0;
            end
        end
        while (exp_q.size() < 16) exp_q.push_back(exp_q[$] + STEP);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_redirect(input logic [31:0] a);
        redirect_addr = a;
        redirect      = 1'b1;
        step(1);
        redirect      = 1'b0;
    endtask

    task automatic finish_store(input logic [31:0] a, input logic [31:0] d, input int s0, input int w0);
        bit seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (st_ack) begin
                seen = 1'b1;
                break;
            end
        end
        st_req = 1'b0;
        check("st_ack_seen", 64'(seen), 64'd1);
        step(2);
        check("st_ack_count", 64'(st_ack_cnt - s0), 64'd1);
        if (wr_log.size() > w0) check("store_bus", wr_log[w0], {a, d});
        else check("store_bus_missing", 64'(wr_log.size() - w0), 64'd1);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int s0 = st_ack_cnt;
        int w0 = wr_log.size();
        st_addr = a;
        st_data = d;
        st_req  = 1'b1;
        finish_store(a, d, s0, w0);
    endtask

    task automatic wait_read_after(input int n0, input string name, input logic [31:0] exp_addr);
        for (int k = 0; k < 60 && rd_log.size() <= n0; k++) step(1);
        if (rd_log.size() > n0) check(name, 64'(rd_log[n0]), 64'(exp_addr));
        else check({name, "_timeout"}, 64'(rd_log.size()), 64'(n0 + 1));
    endtask

    task automatic wait_first_ack(input int a0, input string name, input logic [31:0] exp_pc);
        for (int k = 0; k < 60 && ack_cnt <= a0; k++) step(1);
        if (ack_cnt > a0) check(name, 64'(last_ack_pc), 64'(exp_pc));
        else check({name, "_timeout"}, 64'(ack_cnt), 64'(a0 + 1));
    endtask

    task automatic wait_read_in_flight(input bit need_ack);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (w_bus.W_STB && !w_bus.W_WRITE && (w_bus.W_ACK == need_ack)) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        check("read_in_flight_wait", 64'(ok), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0, a0, s0, w0, r;
        rst = 1'b1; f_enable = 1'b0; redirect = 1'b0; redirect_addr = '0;
        st_req = 1'b0; st_addr = '0; st_data = '0;
        w_bus.W_ACK = 1'b0; w_bus.W_DATA_I = '0;
        #3;
        check("reset_data_o", 64'(data_o), 64'd0);
        check("reset_pc_o", 64'(pc_o), 64'd0);
        check("reset_flags", 64'({ack, st_ack, w_bus.W_STB, w_bus.W_WRITE}), 64'd0);
        check("reset_w_addr", 64'(w_bus.W_ADDR), 64'd0);
        check("reset_w_data", 64'(w_bus.W_DATA_O), 64'd0);
        step(2);
        rst = 1'b0;

        // zero-wait streaming from RESET_PC
        wait_mode = 0;
        f_enable  = 1'b1;
        a0 = ack_cnt;
        step(40);
        check("stream_throughput", 64'((ack_cnt - a0) >= 15), 64'd1);

        // core stalled: the buffer fills with exactly DEPTH reads
        f_enable = 1'b0;
        rst = 1'b1;
        step(2);
        n0 = rd_log.size();
        rst = 1'b0;
        step(20);
        check("fill_read_count", 64'(rd_log.size() - n0), 64'(DEPTH));
        if (rd_log.size() >= n0 + 4) check("fill_last_addr", 64'(rd_log[n0 + 3]), 64'h0C);
        check("fill_stb_idle", 64'(w_bus.W_STB), 64'd0);
        f_enable = 1'b1;
        a0 = ack_cnt;
        step(5);
        check("drain_back_to_back", 64'(ack_cnt - a0), 64'd4);

        // redirect while a slow read is outstanding
        wait_mode = 3;
        wait_read_in_flight(1'b0);
        n0 = rd_log.size();
        pulse_redirect(32'h100);
        a0 = ack_cnt;
        wait_read_after(n0, "redirect_read_addr", 32'h100);
        wait_first_ack(a0, "redirect_first_pc", 32'h100);

        // store straight out of reset beats the pending prefetch
        wait_mode = 0;
        rst = 1'b1;
        n0 = txn_log.size();
        r  = rd_log.size();
        s0 = st_ack_cnt;
        w0 = wr_log.size();
        st_addr = 32'h2000;
        st_data = 32'hDEAD_BEEF;
        st_req  = 1'b1;
        step(1);
        rst = 1'b0;
        finish_store(32'h2000, 32'hDEAD_BEEF, s0, w0);
        if (txn_log.size() > n0) check("store_first_txn", 64'(txn_log[n0]), 64'({1'b1, 32'h2000}));
        else check("store_first_txn_missing", 64'(txn_log.size()), 64'(n0 + 1));
        wait_read_after(r, "post_store_read_addr", RESET_PC);

        // redirect on the W_ACK edge and on a pop edge
        f_enable = 1'b0;
        step(16);
        f_enable = 1'b1;
        wait_read_in_flight(1'b1);
        n0 = rd_log.size();
        pulse_redirect(32'h200);
        a0 = ack_cnt;
        wait_read_after(n0, "redirect_on_ack_read_addr", 32'h200);
        wait_first_ack(a0, "redirect_on_ack_first_pc", 32'h200);

        // address wrap through the top of the space
        pulse_redirect(32'hFFFF_FFF8);
        step(30);

        // reset in the middle of a slow read
        wait_mode = 3;
        wait_read_in_flight(1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_flags", 64'({ack, st_ack, w_bus.W_STB, w_bus.W_WRITE}), 64'd0);
        check("midreset_w_addr", 64'(w_bus.W_ADDR), 64'd0);
        check("midreset_pc_o", 64'(pc_o), 64'd0);
        check("midreset_data_o", 64'(data_o), 64'd0);
        r = rd_log.size();
        step(2);
        rst = 1'b0;
        wait_read_after(r, "midreset_first_read", RESET_PC);

        // randomized traffic
        wait_mode = -1;
        for (int i = 0; i < 300; i++) begin
            f_enable = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 4) pulse_redirect($urandom & 32'hFFFF_FFFC);
            else if (r < 7) do_store($urandom & 32'hFFFF_FFFC, $urandom);
            else step(1);
        end
        f_enable = 1'b1;
        step(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
